ad2dma_deadlock_reporter: RTL and testbench

- Consumer end of the ad2dma deadlock-monitor interface. Takes the monitor's `block` flag and per-channel `axis_block_info` fields.
- Qualifies a deadlock when `block` stays asserted for `threshold` consecutive cycles.
- On qualification, snapshots the info and sends a 3-beat report frame to the host over AXI-Stream.
- Sits beside ad2dma_ad2dma_inst in the PYNQ overlay. Its report stream feeds a debug DMA/FIFO.

---
 rtl/ad2dma_dbg_pkg.sv | 33 +++
 rtl/ad2dma_report_serializer.sv | 60 ++++++
 rtl/ad2dma_deadlock_reporter.sv | 154 +++++++++++++++
 tb/tb_ad2dma_deadlock_reporter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ad2dma_dbg_pkg.sv
// Shared constants, FSM encodings and report payload for the ad2dma deadlock reporter.
package ad2dma_dbg_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_WATCH = 3'd1;
  localparam logic [STATE_W-1:0] ST_SEND0 = 3'd2;
  localparam logic [STATE_W-1:0] ST_SEND1 = 3'd3;
  localparam logic [STATE_W-1:0] ST_SEND2 = 3'd4;
  localparam logic [STATE_W-1:0] ST_HOLD  = 3'd5;

  localparam logic [15:0] REPORT_MAGIC = 16'hDEAD;
  localparam int unsigned REPORT_BEATS = 3;

  localparam int unsigned BEAT_W = 2;
  localparam logic [BEAT_W-1:0] BEAT_HDR  = 2'd0;
  localparam logic [BEAT_W-1:0] BEAT_INFO = 2'd1;
  localparam logic [BEAT_W-1:0] BEAT_TS   = BEAT_W'(REPORT_BEATS - 1);

  // Three-word report snapshot, header word in the low slot
  typedef struct packed {
    logic [31:0] ts;
    logic [31:0] info;
    logic [31:0] hdr;
  } report_frame_t;

  // A monitor field marks its channel blocked with any nonzero code
  function automatic logic field_blocked(input logic [1:0] field);
    return |field;
  endfunction

endpackage

// File: rtl/ad2dma_report_serializer.sv
// Streams a latched three-word report over AXI-Stream, holding each beat until accepted.
module ad2dma_report_serializer
  import ad2dma_dbg_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          start_c,
  input  report_frame_t frame,
  output logic [31:0]   m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          m_axis_tlast,
  output logic          done_c
);

  logic [BEAT_W-1:0] beat_q;
  logic [31:0]       info_q;
  logic [31:0]       ts_q;
  logic              handshake_c;

  assign handshake_c = m_axis_tvalid && m_axis_tready;
  assign done_c      = handshake_c && (beat_q == BEAT_TS);

  // Load the snapshot on start, then advance one beat per accepted transfer
  always_ff @(posedge clock) begin
    if (reset) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      beat_q        <= BEAT_HDR;
      info_q        <= '0;
      ts_q          <= '0;
    end else if (start_c) begin
      m_axis_tdata  <= frame.hdr;
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= 1'b0;
      beat_q        <= BEAT_HDR;
      info_q        <= frame.info;
      ts_q          <= frame.ts;
    end else if (handshake_c) begin
      case (beat_q)
        BEAT_HDR: begin
          m_axis_tdata <= info_q;
          beat_q       <= BEAT_INFO;
        end
        BEAT_INFO: begin
          m_axis_tdata <= ts_q;
          m_axis_tlast <= 1'b1;
          beat_q       <= BEAT_TS;
        end
        default: begin
          m_axis_tvalid <= 1'b0;
          m_axis_tlast  <= 1'b0;
          beat_q        <= BEAT_HDR;
        end
      endcase
    end
  end

endmodule

// File: rtl/ad2dma_deadlock_reporter.sv
// Qualifies sustained monitor blocking as a deadlock and emits a report frame to the host.
module ad2dma_deadlock_reporter
  import ad2dma_dbg_pkg::*;
#(
  parameter int unsigned NUM_CHAN = 2,
  parameter int unsigned INFO_W   = 2 * NUM_CHAN,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [CNT_W-1:0]  threshold,
  input  logic              block,
  input  logic [INFO_W-1:0] axis_block_info,
  output logic [31:0]       m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              deadlock,
  output logic [7:0]        event_count
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [31:0]        timestamp_q;
  logic [NUM_CHAN-1:0] chan_mask_c;
  logic [CNT_W-1:0]   thresh_last_c;
  logic [7:0]         event_next_c;
  logic               capture_c;
  logic               handshake_c;
  logic               done_c;
  report_frame_t      frame_c;

  // Per-channel blocked mask from the monitor's 2-bit fields
  always_comb begin
    chan_mask_c = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      chan_mask_c[i] = field_blocked(axis_block_info[2*i +: 2]);
    end
  end

  // Capture fires on the block cycle that completes the required run (threshold 0 acts as 1)
  assign thresh_last_c = (threshold == '0) ? '0 : threshold - CNT_W'(1);
  assign capture_c     = (state_q == ST_WATCH) && block && (stall_q == thresh_last_c);
  assign handshake_c   = m_axis_tvalid && m_axis_tready;

  // Event count after this capture; a simultaneous clear restarts the count at one
  always_comb begin
    event_next_c = event_count + 8'd1;
    if (clear) begin
      event_next_c = 8'd1;
    end else if (event_count == 8'hFF) begin
      event_next_c = 8'hFF;
    end
  end

  // Snapshot words handed to the serializer on capture
  always_comb begin
    frame_c      = '0;
    frame_c.hdr  = {REPORT_MAGIC, 8'h00, event_next_c};
    frame_c.info = 32'({chan_mask_c, axis_block_info});
    frame_c.ts   = timestamp_q;
  end

  // Qualification FSM next-state and stall counter update
  always_comb begin
    state_d = state_q;
    stall_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_WATCH;
        end
      end
      ST_WATCH: begin
        if (block) begin
          stall_d = (stall_q == {CNT_W{1'b1}}) ? stall_q : stall_q + CNT_W'(1);
        end
        if (capture_c) begin
          state_d = ST_SEND0;
          stall_d = '0;
        end else if (!enable) begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND0: begin
        if (handshake_c) begin
          state_d = ST_SEND1;
        end
      end
      ST_SEND1: begin
        if (handshake_c) begin
          state_d = ST_SEND2;
        end
      end
      ST_SEND2: begin
        if (done_c) begin
          state_d = enable ? ST_HOLD : ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (!block) begin
          state_d = ST_WATCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, stall counter and free-running timestamp registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      stall_q     <= '0;
      timestamp_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_q     <= stall_d;
      timestamp_q <= timestamp_q + 32'd1;
    end
  end

  // Sticky deadlock flag and saturating capture count; capture beats clear
  always_ff @(posedge clock) begin
    if (reset) begin
      deadlock    <= 1'b0;
      event_count <= '0;
    end else if (capture_c) begin
      deadlock    <= 1'b1;
      event_count <= event_next_c;
    end else if (clear) begin
      deadlock    <= 1'b0;
      event_count <= '0;
    end
  end

  ad2dma_report_serializer u_serializer (
    .clock         (clock),
    .reset         (reset),
    .start_c       (capture_c),
    .frame         (frame_c),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .done_c        (done_c)
  );

endmodule

// File: tb/tb_ad2dma_deadlock_reporter.sv
// Directed plus randomized bench for ad2dma_deadlock_reporter against a behavioural model.
module tb_ad2dma_deadlock_reporter;

  localparam int unsigned NUM_CHAN = 2;
  localparam int unsigned INFO_W   = 2 * NUM_CHAN;
  localparam int unsigned CNT_W    = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic              clear;
  logic [CNT_W-1:0]  threshold;
  logic              block;
  logic [INFO_W-1:0] axis_block_info;
  logic [31:0]       m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic              deadlock;
  logic [7:0]        event_count;

  int total = 0;
  int bad   = 0;

  // Behavioural model: watching/holding flags, run length of block, beats still owed
  bit          m_watch;
  bit          m_hold;
  int          m_run;
  int          m_left;
  int          m_hs;
  bit          m_dead;
  int          m_ec;
  logic [31:0] m_ts;
  logic [31:0] m_frame [3];
  logic [31:0] obs_q [$];

  always #5 clock = ~clock;

  ad2dma_deadlock_reporter #(
    .NUM_CHAN (NUM_CHAN),
    .INFO_W   (INFO_W),
    .CNT_W    (CNT_W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .clear           (clear),
    .threshold       (threshold),
    .block           (block),
    .axis_block_info (axis_block_info),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tlast    (m_axis_tlast),
    .deadlock        (deadlock),
    .event_count     (event_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance the model by one cycle using the inputs currently applied
  task automatic model_step();
    int  th_eff;
    bit  cap;
    int  mask;
    if (reset) begin
      m_watch = 0; m_hold = 0; m_run = 0; m_left = 0;
      m_dead = 0; m_ec = 0; m_ts = 32'd0;
      return;
    end
    th_eff = (threshold == 0) ? 1 : int'(threshold);
    cap = 0;
    if (m_left > 0) begin
      if (m_axis_tready) begin
        m_left--;
        m_hs++;
        if (m_left == 0) m_hold = enable;
      end
    end else if (m_hold) begin
      if (!enable) m_hold = 0;
      else if (!block) begin m_hold = 0; m_watch = 1; m_run = 0; end
    end else if (m_watch) begin
      if (block && m_run == th_eff - 1) cap = 1;
      else if (!enable) m_watch = 0;
      m_run = block ? m_run + 1 : 0;
    end else if (enable) begin
      m_watch = 1;
      m_run = 0;
    end
    if (cap) begin
      m_ec = clear ? 1 : ((m_ec < 255) ? m_ec + 1 : 255);
      m_dead = 1;
      mask = 0;
      for (int i = 0; i < NUM_CHAN; i++)
        if (int'(axis_block_info[2*i +: 2]) != 0) mask |= (1 << i);
      m_frame[0] = {16'hDEAD, 8'h00, 8'(m_ec)};
      m_frame[1] = 32'((mask << INFO_W) | int'(axis_block_info));
      m_frame[2] = m_ts;
      m_watch = 0;
      m_left = 3;
    end else if (clear) begin
      m_dead = 0;
      m_ec = 0;
    end
    m_ts = m_ts + 32'd1;
  endtask

  // One clock: record accepted beats, step the model, compare after the edge
  task automatic tick();
    if (m_axis_tvalid === 1'b1 && m_axis_tready && !reset) obs_q.push_back(m_axis_tdata);
    model_step();
    @(posedge clock);
    #1;
    check("tvalid", 32'(m_axis_tvalid), 32'(m_left > 0));
    check("tlast", 32'(m_axis_tlast), 32'(m_left == 1));
    if (m_left > 0) check("tdata", m_axis_tdata, m_frame[3 - m_left]);
    check("deadlock", 32'(deadlock), 32'(m_dead));
    check("event_count", 32'(event_count), 32'(m_ec));
  endtask

  task automatic drain();
    for (int k = 0; k < 64 && m_left > 0; k++) tick();
    check("frame_drained", 32'(m_axis_tvalid), 32'd0);
  endtask

  initial begin
    m_hs = 0;
    reset = 1'b1; enable = 1'b0; clear = 1'b0; block = 1'b0;
    threshold = 16'd4; axis_block_info = '0; m_axis_tready = 1'b1;
    tick(); tick();
    check("rst_tdata", m_axis_tdata, 32'd0);
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_event_count", 32'(event_count), 32'd0);

    // Short burst below threshold
    reset = 1'b0; enable = 1'b1;
    tick();
    block = 1'b1; repeat (3) tick();
    block = 1'b0; repeat (3) tick();
    check("short_no_beats", 32'(obs_q.size()), 32'd0);
    check("short_deadlock", 32'(deadlock), 32'd0);

    // Qualified capture on the fourth block cycle, timestamp 10
    axis_block_info = 4'b0010; block = 1'b1;
    repeat (4) tick();
    check("cap_tvalid", 32'(m_axis_tvalid), 32'd1);
    drain();
    repeat (100) tick();
    check("one_frame_beats", 32'(obs_q.size()), 32'd3);
    check("beat0", obs_q[0], 32'hDEAD0001);
    check("beat1", obs_q[1], 32'h00000012);
    check("beat2_ts", obs_q[2], 32'd10);
    check("cap_deadlock", 32'(deadlock), 32'd1);

    // Drop block one cycle, re-qualify
    block = 1'b0; tick();
    block = 1'b1; repeat (4) tick();
    drain();
    check("second_beats", 32'(obs_q.size()), 32'd6);
    check("second_hdr", obs_q[3], 32'hDEAD0002);

    // Backpressure: five stalled cycles per beat
    block = 1'b0; tick();
    block = 1'b1; repeat (4) tick();
    for (int b = 0; b < 3; b++) begin
      m_axis_tready = 1'b0; repeat (5) tick();
      m_axis_tready = 1'b1; tick();
    end
    check("bp_beats", 32'(obs_q.size()), 32'd9);
    check("bp_hdr", obs_q[6], 32'hDEAD0003);
    check("bp_tvalid_after", 32'(m_axis_tvalid), 32'd0);

    // Threshold 0 with a single-cycle pulse, both channels blocked
    threshold = 16'd0;
    block = 1'b0; tick();
    axis_block_info = 4'b1001; block = 1'b1; tick();
    block = 1'b0;
    drain();
    check("th0_beats", 32'(obs_q.size()), 32'd12);
    check("th0_beat1", obs_q[10], 32'h00000039);

    // Clear while beat 1 is presented
    threshold = 16'd4; axis_block_info = 4'b0001;
    tick();
    block = 1'b1; repeat (4) tick();
    tick();
    clear = 1'b1; tick(); clear = 1'b0;
    drain();
    check("clr_beats", 32'(obs_q.size()), 32'd15);
    check("clr_hdr", obs_q[12], 32'hDEAD0005);
    check("clr_deadlock", 32'(deadlock), 32'd0);
    check("clr_event_count", 32'(event_count), 32'd0);

    // Clear coinciding with capture
    block = 1'b0; tick();
    block = 1'b1; repeat (3) tick();
    clear = 1'b1; tick(); clear = 1'b0;
    check("clrcap_deadlock", 32'(deadlock), 32'd1);
    check("clrcap_event_count", 32'(event_count), 32'd1);
    drain();
    check("clrcap_hdr", obs_q[15], 32'hDEAD0001);

    // Reset while beat 1 is presented
    block = 1'b0; tick();
    block = 1'b1; repeat (4) tick();
    tick();
    reset = 1'b1; tick();
    check("rst_mid_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_mid_tlast", 32'(m_axis_tlast), 32'd0);
    check("rst_mid_event_count", 32'(event_count), 32'd0);
    reset = 1'b0;
    m_hs = obs_q.size();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      enable = ($urandom_range(0, 19) != 0);
      clear = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) threshold = CNT_W'($urandom_range(0, 6));
      block = ($urandom_range(0, 3) != 0);
      axis_block_info = INFO_W'($urandom);
      m_axis_tready = ($urandom_range(0, 2) != 0);
      tick();
    end
    m_axis_tready = 1'b1; clear = 1'b0;
    drain();
    check("rand_handshakes", 32'(obs_q.size()), 32'(m_hs));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
